lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store initiator between the core's memory stage and the word-organised data memory.
- Takes one byte-addressed load or store from the core per handshake.
- Splits accesses that cross a 32-bit word boundary into two word beats, drives byte-lane enables and aligned write data, then merges and sign- or zero-extends returned read data.
- Presents one response to the core per request.

Parameters:
- DM_ADDRESS, 9, byte-address width of data memory.
- DATA_W, 32, data width; fixed at 32 (four byte lanes).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  instr[14:12].
- req_addr  in  DM_ADDRESS  byte address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  one-cycle response pulse, for loads and stores.
- resp_rdata  out  DATA_W  extended load result; 0 for stores.
- mem_req  out  1  memory beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  DM_ADDRESS  word-aligned address; [1:0] always 00.
- mem_be  out  4  byte-lane write enables; 0000 on reads.
- mem_wdata  out  DATA_W  lane-aligned write data.
- mem_ready  in  1  memory accepts beat this cycle.
- mem_rdata  in  DATA_W  read data, valid exactly one cycle after an accepted read beat.

Behaviour:
- Memory is little-endian: byte lane k = bits [8k+7:8k].
- Request decode:
  - Size: 000/100 = byte; 001/101 = half; 010 = word.
  - Any other funct3 = word with addr[1:0] forced to 00 (never split).
  - Sign-extend for 000/001; zero-extend for 100/101; word needs no extension.
- Split rule: split when off + size_bytes > 4, where off = addr[1:0]. This covers word at off≠0 and half at off=3; bytes never split.
  - Beat 0: word at {addr[DM_ADDRESS-1:2],00}.
  - Beat 1: next word, address computed modulo 2^DM_ADDRESS (top word wraps to 0).
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
  - IDLE: req_ready=1. On req_valid, capture the request into registers and go to REQ0.
  - REQ0 / REQ1: mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata held stable until mem_ready.
    - Store: on mem_ready, REQ0 goes to REQ1 if split, else RESP; REQ1 goes to RESP.
    - Load: on mem_ready, REQx goes to WAITx.
  - WAIT0 / WAIT1: capture mem_rdata. WAIT0 goes to REQ1 if split, else RESP; WAIT1 goes to RESP.
  - RESP: resp_valid=1 for exactly one cycle, resp_rdata stable; next state IDLE. A new request can be accepted the cycle after RESP.
- Store lanes:
  - Beat 0 enables lanes off .. min(off+size-1, 3).
  - Beat 1 enables lanes 0 .. off+size-5.
  - Data goes to the enabled lanes in ascending byte order of req_wdata.
  - Disabled lanes of mem_wdata are 0.
- Load merge:
  - Bytes are assembled in ascending order: beat-0 lanes from off upward, then beat-1 lanes from 0.
  - The assembled value is truncated to size, then extended.
- Latency with mem_ready tied high, accept in cycle 0:
  - resp_valid in cycle 2: aligned store.
  - resp_valid in cycle 3: split store, or aligned load.
  - resp_valid in cycle 5: split load.
- Outputs outside their states:
  - mem_req=0 and mem_be=0 outside REQx.
  - mem_addr, mem_wdata and mem_we are 0 outside REQx.
- Reset, including mid-transaction:
  - State goes to IDLE; all outputs go to 0 except req_ready=1.
  - Captured data is cleared. The pending beat is dropped and no resp_valid is produced.
  - reset overrides req_valid in the same cycle.
- req_valid outside IDLE is ignored; the core holds the request until accepted.

Test Plan:
- Aligned SW addr=0x010, wdata=0xA1B2C3D4, mem_ready=1 -> single beat: mem_addr=0x010, be=1111, wdata=0xA1B2C3D4; resp_valid cycle 2.
- Split LW addr=0x005; memory word 0x004=0x44332211, 0x008=0x88776655 -> beats at 0x004 then 0x008, be=0000; resp_rdata=0x55443322 in cycle 5.
- LH addr=0x00B (split), word 0x008=0x80xxxxxx, 0x00C lane0=0xFF -> resp_rdata=0xFFFFFF80. Same access with LHU -> 0x0000FF80.
- Split SH at top, addr=0x1FF, wdata=0x0000BEEF -> beat0 mem_addr=0x1FC, be=1000, wdata=0xEF000000; beat1 mem_addr=0x000, be=0001, wdata=0x000000BE.
- Back-pressure: mem_ready low 3 cycles during REQ0 of SB addr=0x002, wdata=0x5A -> be=0100 and wdata=0x005A0000 held stable all 4 cycles; one resp_valid.
- reset asserted in WAIT0 of a split load -> next cycle IDLE, req_ready=1, mem_req=0, no resp_valid; the following aligned LB addr=0x003 completes normally with the correct lane-3 byte.

Source files
------------

// File: rtl/lsu_mem_initiator_if.sv
// Bus bundle for the load/store initiator: core request/response plus the
// word-organised data-memory beat channel.
// master = the initiator itself, slave = its environment (core + memory).
interface lsu_mem_initiator_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    // core side
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    // memory side
    logic                  mem_req;
    logic                  mem_we;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ready;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: turns one byte-addressed core access into one or two
// word beats on a little-endian 32-bit data memory, then merges and extends
// the read data into a single core response.
module lsu_mem_initiator #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    lsu_mem_initiator_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam int WA = DM_ADDRESS - 2;  // word-address width

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    // captured request
    logic              r_we;
    logic [WA-1:0]     r_waddr;
    logic [1:0]        r_off;
    logic [3:0]        r_lanes;   // size as a lane mask: 0001 / 0011 / 1111
    logic              r_sext;
    logic              r_split;
    logic [7:0]        r_be;      // [3:0] beat 0, [7:4] beat 1
    logic [63:0]       r_wd;      // [31:0] beat 0, [63:32] beat 1
    logic [DATA_W-1:0] r_rd0;
    logic [DATA_W-1:0] r_rd1;

    // request decode
    logic              w_f3_legal;
    logic [1:0]        w_off;
    logic [3:0]        w_lanes;
    logic              w_sext;
    logic [7:0]        w_bemask;
    logic [31:0]       w_wmask;
    logic [63:0]       w_wshift;

    // Decode funct3 into size/extension; unknown encodings become an
    // aligned word so they can never split.
    always_comb begin
        w_f3_legal = 1'b0;
        w_lanes    = 4'b1111;
        case (bus.req_funct3)
            3'b000, 3'b100: begin w_lanes = 4'b0001; w_f3_legal = 1'b1; end
            3'b001, 3'b101: begin w_lanes = 4'b0011; w_f3_legal = 1'b1; end
            3'b010:         begin w_lanes = 4'b1111; w_f3_legal = 1'b1; end
            default:        begin w_lanes = 4'b1111; w_f3_legal = 1'b0; end
        endcase
        w_off  = w_f3_legal ? bus.req_addr[1:0] : 2'b00;
        w_sext = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001);
        // Lane enables across both beats; anything landing in [7:4] means split.
        w_bemask = {4'b0000, w_lanes} << w_off;
        w_wmask  = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};
        // Store data truncated to size and slid into lane position.
        w_wshift = {32'h0, bus.req_wdata & w_wmask} << {w_off, 3'b000};
    end

    // Next-state logic of the beat sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_state_nxt = S_REQ0;
            S_REQ0:  if (bus.mem_ready)
                         w_state_nxt = !r_we   ? S_WAIT0 :
                                       r_split ? S_REQ1  : S_RESP;
            S_WAIT0: w_state_nxt = r_split ? S_REQ1 : S_RESP;
            S_REQ1:  if (bus.mem_ready)
                         w_state_nxt = r_we ? S_RESP : S_WAIT1;
            S_WAIT1: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Capture the request on acceptance and read beats in the WAIT states.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_off   <= 2'b00;
            r_lanes <= 4'b0000;
            r_sext  <= 1'b0;
            r_split <= 1'b0;
            r_be    <= 8'h00;
            r_wd    <= 64'h0;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end else begin
            if (r_state == S_IDLE && bus.req_valid) begin
                r_we    <= bus.req_we;
                r_waddr <= bus.req_addr[DM_ADDRESS-1:2];
                r_off   <= w_off;
                r_lanes <= w_lanes;
                r_sext  <= w_sext;
                r_split <= |w_bemask[7:4];
                r_be    <= w_bemask;
                r_wd    <= w_wshift;
                r_rd0   <= '0;
                r_rd1   <= '0;
            end
            if (r_state == S_WAIT0) r_rd0 <= bus.mem_rdata;
            if (r_state == S_WAIT1) r_rd1 <= bus.mem_rdata;
        end
    end

    // Load merge: beat-0 bytes from the offset upward, then beat-1 bytes.
    logic [63:0]       w_cat;
    logic [31:0]       w_asm;
    logic [DATA_W-1:0] w_ext;
    logic              w_in_req;
    logic              w_beat1;
    logic [WA-1:0]     w_waddr_cur;

    // Assemble, truncate and extend the load result.
    always_comb begin
        w_cat = {r_rd1, r_rd0};
        w_asm = w_cat[{r_off, 3'b000} +: 32];
        case (r_lanes)
            4'b0001: w_ext = {{24{r_sext & w_asm[7]}},  w_asm[7:0]};
            4'b0011: w_ext = {{16{r_sext & w_asm[15]}}, w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

    assign w_in_req    = (r_state == S_REQ0) || (r_state == S_REQ1);
    assign w_beat1     = (r_state == S_REQ1);
    // Beat 1 targets the next word; the top word wraps to 0 naturally.
    assign w_waddr_cur = w_beat1 ? r_waddr + {{(WA-1){1'b0}}, 1'b1} : r_waddr;

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = (r_state == S_RESP && !r_we) ? w_ext : '0;

    assign bus.mem_req    = w_in_req;
    assign bus.mem_we     = w_in_req & r_we;
    assign bus.mem_addr   = w_in_req ? {w_waddr_cur, 2'b00} : '0;
    assign bus.mem_be     = (w_in_req && r_we) ? (w_beat1 ? r_be[7:4] : r_be[3:0]) : 4'b0000;
    assign bus.mem_wdata  = (w_in_req && r_we) ? (w_beat1 ? r_wd[63:32] : r_wd[31:0]) : '0;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomised self-checking bench for lsu_mem_initiator. A byte-array
// reference computes expected beats, lane enables, data and load results;
// a word-array memory model answers the DUT's beats.
module tb_lsu_mem_initiator;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;

    lsu_mem_initiator_if #(.DM_ADDRESS(AW), .DATA_W(32)) bus();

    lsu_mem_initiator #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] memw [128];   // memory the DUT talks to
    logic [7:0]  refb [512];   // reference byte image
    logic        ld_en = 1'b0;
    logic [6:0]  ld_idx = '0;
    logic [31:0] ld_val = '0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // Memory model: applies accepted writes, returns read data one cycle
    // after an accepted read beat and garbage otherwise.
    always @(posedge clk) begin
        if (ld_en) memw[ld_idx] <= ld_val;
        if (bus.mem_req && bus.mem_ready && bus.mem_we)
            memw[bus.mem_addr[8:2]] <= merge(memw[bus.mem_addr[8:2]], bus.mem_wdata, bus.mem_be);
        if (bus.mem_req && bus.mem_ready && !bus.mem_we)
            bus.mem_rdata <= memw[bus.mem_addr[8:2]];
        else
            bus.mem_rdata <= $urandom;
    end

    task automatic set_word(input int idx, input logic [31:0] v);
        ld_en  = 1'b1;
        ld_idx = 7'(idx);
        ld_val = v;
        for (int k = 0; k < 4; k++) refb[idx*4 + k] = v[8*k +: 8];
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // One core transaction, entered and left at a negedge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] wd, input int rdy_pct, input int stall,
                          output logic [31:0] rdata);
        int sz, nb, bi, lat, elat, st;
        logic [8:0] base, ba;
        logic [6:0] ea [2];
        logic [3:0] ebe [2];
        logic [31:0] ewd [2];
        logic [31:0] er;
        logic done;
        base = a; er = '0; nb = 0; bi = 0; lat = 0; done = 1'b0; st = stall;
        rdata = '0;
        case (f3)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            3'b010:         sz = 4;
            default: begin sz = 4; base = {a[8:2], 2'b00}; end
        endcase
        for (int i = 0; i < sz; i++) begin
            ba = base + 9'(i);
            if (nb == 0 || ba[8:2] != ea[nb-1]) begin
                ea[nb] = ba[8:2]; ebe[nb] = '0; ewd[nb] = '0; nb++;
            end
            if (we) begin
                ebe[nb-1][ba[1:0]] = 1'b1;
                ewd[nb-1][8*ba[1:0] +: 8] = wd[8*i +: 8];
                refb[ba] = wd[8*i +: 8];
            end
            er[8*i +: 8] = refb[ba];
        end
        if (sz == 1 && f3 == 3'b000) er = {{24{er[7]}}, er[7:0]};
        if (sz == 2 && f3 == 3'b001) er = {{16{er[15]}}, er[15:0]};
        if (we) er = '0;
        elat = we ? 1 + nb : 1 + 2 * nb;

        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 80 && !done; c++) begin
            if (bus.resp_valid) begin
                lat = c; rdata = bus.resp_rdata; done = 1'b1;
            end else begin
                if (bus.mem_req) begin
                    if (bi >= nb) begin
                        chk("extra_beat", 64'(bi), 64'(nb));
                    end else begin
                        chk("beat_addr", 64'(bus.mem_addr), 64'({ea[bi], 2'b00}));
                        chk("beat_we", 64'(bus.mem_we), 64'(we));
                        chk("beat_be", 64'(bus.mem_be), 64'(ebe[bi]));
                        chk("beat_wdata", 64'(bus.mem_wdata), 64'(ewd[bi]));
                    end
                    if (st > 0) begin bus.mem_ready = 1'b0; st--; end
                    else bus.mem_ready = ($urandom_range(99) < rdy_pct);
                    if (bus.mem_ready) bi++;
                end else begin
                    chk("idle_bus", {18'h0, bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.mem_we}, 64'h0);
                    bus.mem_ready = 1'($urandom);
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            chk("resp_timeout", 64'd0, 64'd1);
        end else begin
            chk("beat_count", 64'(bi), 64'(nb));
            chk("resp_rdata", 64'(rdata), 64'(er));
            if (rdy_pct == 100 && stall == 0) chk("latency", 64'(lat), 64'(elat));
            @(negedge clk);
            chk("post_resp", {62'h0, bus.resp_valid, bus.req_ready}, 64'h1);
        end
    endtask

    initial begin
        logic [31:0] r;
        int seen;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_outputs", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr,
                            bus.mem_wdata, bus.resp_valid, bus.resp_rdata}, 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 128; i++) set_word(i, $urandom);

        // aligned SW
        do_req(1'b1, 3'b010, 9'h010, 32'hA1B2C3D4, 100, 0, r);
        // split LW
        set_word(1, 32'h44332211);
        set_word(2, 32'h88776655);
        do_req(1'b0, 3'b010, 9'h005, 32'h0, 100, 0, r);
        chk("lw_split_val", 64'(r), 64'h55443322);
        // split LH / LHU
        set_word(2, 32'h80665544);
        set_word(3, 32'h123456FF);
        do_req(1'b0, 3'b001, 9'h00B, 32'h0, 100, 0, r);
        chk("lh_split_val", 64'(r), 64'hFFFFFF80);
        do_req(1'b0, 3'b101, 9'h00B, 32'h0, 100, 0, r);
        chk("lhu_split_val", 64'(r), 64'h0000FF80);
        // split SH wrapping past the top word
        do_req(1'b1, 3'b001, 9'h1FF, 32'h0000BEEF, 100, 0, r);
        do_req(1'b0, 3'b101, 9'h1FF, 32'h0, 100, 0, r);
        chk("sh_wrap_readback", 64'(r), 64'h0000BEEF);
        // SB under three cycles of back-pressure
        do_req(1'b1, 3'b000, 9'h002, 32'h0000005A, 100, 3, r);
        do_req(1'b0, 3'b100, 9'h002, 32'h0, 100, 0, r);
        chk("sb_bp_readback", 64'(r), 64'h5A);

        // reset during WAIT0 of a split load
        bus.mem_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 9'h005;
        @(negedge clk);               // REQ0
        bus.req_valid = 1'b0;
        @(negedge clk);               // WAIT0
        chk("pre_rst_wait0", {62'h0, bus.mem_req, bus.req_ready}, 64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle", {61'h0, bus.req_ready, bus.mem_req, bus.resp_valid}, 64'h4);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_req) seen++;
        end
        chk("rst_no_resp", 64'(seen), 64'd0);
        do_req(1'b0, 3'b000, 9'h003, 32'h0, 100, 0, r);

        // reset wins over a simultaneous request
        reset = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 9'h040; bus.req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rst_over_valid", {62'h0, bus.req_ready, bus.mem_req}, 64'h2);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);

        // random traffic
        for (int t = 0; t < 150; t++) begin
            logic [8:0] a;
            a = 9'($urandom);
            if ($urandom_range(7) == 0) a = 9'h1FC | 9'($urandom_range(3));
            do_req(1'($urandom), 3'($urandom), a, $urandom,
                   ($urandom_range(2) == 0) ? 100 : 60, 0, r);
        end

        // memory image must match the reference byte image
        for (int i = 0; i < 128; i++)
            chk("mem_image", 64'(memw[i]),
                64'({refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
